// File: rtl/bimodal_branch_predictor.sv
// Bimodal branch predictor: table of saturating counters indexed by PC, plus perf counters.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR the index with a global taken/not-taken history.
module bimodal_branch_predictor #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BHT_ENTRIES  = 64,
    parameter int unsigned COUNTER_BITS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus_four,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic            branch,
    output logic            branch_predicted_taken,
    output logic [XLEN-1:0] predicted_next_instruction,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic            update_mispredicted,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);
    localparam int unsigned IdxW = $clog2(BHT_ENTRIES);
    localparam logic [COUNTER_BITS-1:0] WeakNt =
        COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);

    logic [IdxW-1:0]         rd_idx;
    logic [IdxW-1:0]         wr_idx;
    logic [COUNTER_BITS-1:0] cnt_q [BHT_ENTRIES];
    logic [COUNTER_BITS-1:0] cnt_d [BHT_ENTRIES];
    logic [COUNTER_BITS-1:0] wr_cnt;
    logic [COUNTER_BITS-1:0] rd_cnt;
    logic [31:0]             branch_count_q, branch_count_d;
    logic [31:0]             mispredict_count_q, mispredict_count_d;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [IdxW-1:0] hist_q, hist_d;

    // Both ports use the pre-update history, so an update sees the same index its prediction did.
    assign rd_idx = pc[IdxW+1:2] ^ hist_q;
    assign wr_idx = update_pc[IdxW+1:2] ^ hist_q;

    always_comb begin
        hist_d = hist_q;
        if (update_valid) begin
            hist_d = {hist_q[IdxW-2:0], update_taken};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign rd_idx = pc[IdxW+1:2];
    assign wr_idx = update_pc[IdxW+1:2];
`endif

    // Reads come straight from the flops, so a same-index update is seen only next cycle.
    assign rd_cnt                     = cnt_q[rd_idx];
    assign branch_predicted_taken     = jump | (branch & rd_cnt[COUNTER_BITS-1]);
    assign predicted_next_instruction = branch_predicted_taken ? branch_target : pc_plus_four;

    always_comb begin
        wr_cnt = cnt_q[wr_idx];
        if (update_taken && (wr_cnt != {COUNTER_BITS{1'b1}})) begin
            wr_cnt = wr_cnt + 1'b1;
        end else if (!update_taken && (wr_cnt != '0)) begin
            wr_cnt = wr_cnt - 1'b1;
        end
    end

    always_comb begin
        cnt_d              = cnt_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (update_valid) begin
            cnt_d[wr_idx]  = wr_cnt;
            branch_count_d = branch_count_q + 32'd1;
            if (update_mispredicted) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                cnt_q[i] <= WeakNt;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            cnt_q              <= cnt_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    logic unused_bits;
    assign unused_bits = ^{pc[XLEN-1:IdxW+2], pc[1:0],
                           update_pc[XLEN-1:IdxW+2], update_pc[1:0]};

endmodule

// File: tb/tb_bimodal_branch_predictor.sv
// Directed, table-driven bench for bimodal_branch_predictor (default 32/64/2 configuration).
module tb_bimodal_branch_predictor;
    localparam logic [31:0] Target = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, pc_plus_four, branch_target, update_pc;
    logic        jump, branch, update_valid, update_taken, update_mispredicted;
    logic        branch_predicted_taken;
    logic [31:0] predicted_next_instruction, branch_count, mispredict_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bimodal_branch_predictor dut (
        .clk                        (clk),
        .reset                      (reset),
        .pc                         (pc),
        .pc_plus_four               (pc_plus_four),
        .branch_target              (branch_target),
        .jump                       (jump),
        .branch                     (branch),
        .branch_predicted_taken     (branch_predicted_taken),
        .predicted_next_instruction (predicted_next_instruction),
        .update_valid               (update_valid),
        .update_pc                  (update_pc),
        .update_taken               (update_taken),
        .update_mispredicted        (update_mispredicted),
        .branch_count               (branch_count),
        .mispredict_count           (mispredict_count)
    );

    typedef struct {
        logic        upd_v;
        logic [31:0] upd_pc;
        logic        upd_t;
        logic        upd_m;
        logic [31:0] pc;
        logic        br;
        logic        jmp;
        logic        exp_taken;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_pred(input logic [31:0] p, input logic b, input logic j);
        pc           = p;
        pc_plus_four = p + 32'd4;
        branch       = b;
        jump         = j;
    endtask

    task automatic drive_upd(input logic v, input logic [31:0] p, input logic t, input logic m);
        update_valid        = v;
        update_pc           = p;
        update_taken        = t;
        update_mispredicted = m;
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] up, input logic t,
                                input logic m, input logic [31:0] p, input logic b,
                                input logic j, input logic et);
        vec_t r;
        r.upd_v = v; r.upd_pc = up; r.upd_t = t; r.upd_m = m;
        r.pc = p; r.br = b; r.jmp = j; r.exp_taken = et;
        r.exp_next = et ? Target : p + 32'd4;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // Each row: prediction checked before the edge, then the update is applied on it.
        vecs[0]  = mk(0, 32'h40, 0, 0, 32'h40,  1, 0, 0);  // reset value: weakly not taken
        vecs[1]  = mk(1, 32'h40, 1, 0, 32'h40,  1, 0, 0);  // read-old during update, 1->2
        vecs[2]  = mk(0, 32'h40, 0, 0, 32'h40,  1, 0, 1);  // trained once: taken
        vecs[3]  = mk(1, 32'h40, 1, 0, 32'h140, 1, 0, 1);  // alias of 0x40, 2->3
        vecs[4]  = mk(1, 32'h40, 1, 0, 32'h44,  1, 0, 0);  // neighbour untouched, 3 sat
        vecs[5]  = mk(1, 32'h40, 1, 0, 32'h40,  1, 0, 1);  // 3 sat
        vecs[6]  = mk(1, 32'h40, 0, 0, 32'h40,  1, 0, 1);  // 3->2
        vecs[7]  = mk(1, 32'h40, 0, 0, 32'h40,  1, 0, 1);  // 2->1
        vecs[8]  = mk(1, 32'h40, 0, 0, 32'h40,  1, 0, 0);  // 1->0
        vecs[9]  = mk(1, 32'h40, 0, 0, 32'h40,  1, 0, 0);  // 0 sat
        vecs[10] = mk(0, 32'h40, 0, 0, 32'h40,  1, 0, 0);
        vecs[11] = mk(0, 32'h40, 0, 0, 32'h44,  0, 1, 1);  // jump always taken
        vecs[12] = mk(0, 32'h40, 0, 0, 32'h40,  0, 0, 0);  // neither branch nor jump
        vecs[13] = mk(0, 32'h40, 1, 1, 32'h40,  1, 0, 0);  // invalid update ignored
        vecs[14] = mk(0, 32'h40, 0, 0, 32'h40,  1, 0, 0);
        vecs[15] = mk(0, 32'h40, 0, 0, 32'h40,  1, 1, 1);  // jump at 0x40 must not train
        vecs[16] = mk(0, 32'h40, 0, 0, 32'h40,  1, 0, 0);

        branch_target = Target;
        drive_pred(32'h40, 1'b0, 1'b0);
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("reset_branch_count", branch_count, 32'd0);
        check("reset_mispredict_count", mispredict_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive_pred(vecs[i].pc, vecs[i].br, vecs[i].jmp);
            drive_upd(vecs[i].upd_v, vecs[i].upd_pc, vecs[i].upd_t, vecs[i].upd_m);
            #1;
            check($sformatf("vec%0d_taken", i), {31'd0, branch_predicted_taken},
                  {31'd0, vecs[i].exp_taken});
            check($sformatf("vec%0d_next", i), predicted_next_instruction, vecs[i].exp_next);
        end
        @(negedge clk);
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("table_branch_count", branch_count, 32'd8);
        check("table_mispredict_count", mispredict_count, 32'd0);

        // Ten updates, three mispredicted, all taken at 0x40 so the counter ends strongly taken.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_upd(1'b1, 32'h40, 1'b1, (i % 3 == 0) && (i != 0));
        end
        @(negedge clk);
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        drive_pred(32'h40, 1'b1, 1'b0);
        #1;
        check("seq_branch_count", branch_count, 32'd10);
        check("seq_mispredict_count", mispredict_count, 32'd3);
        check("seq_trained_taken", {31'd0, branch_predicted_taken}, 32'd1);

        // Asynchronous reset mid-cycle while updates are still streaming.
        drive_upd(1'b1, 32'h40, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_branch_count", branch_count, 32'd0);
        check("async_reset_mispredict_count", mispredict_count, 32'd0);
        check("async_reset_pred", {31'd0, branch_predicted_taken}, 32'd0);
        check("async_reset_next", predicted_next_instruction, 32'h44);

        // Update coincident with reset held across the edge is discarded.
        @(posedge clk);
        #1;
        check("reset_edge_branch_count", branch_count, 32'd0);
        check("reset_edge_pred", {31'd0, branch_predicted_taken}, 32'd0);
        @(negedge clk);
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_pred", {31'd0, branch_predicted_taken}, 32'd0);
        check("post_reset_branch_count", branch_count, 32'd0);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
        // Two taken updates at 0x40 land on index 16 then 17; history becomes 0b11.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_upd(1'b1, 32'h40, 1'b1, 1'b0);
        end
        @(negedge clk);
        drive_upd(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("gshare_history", {26'd0, dut.hist_q}, 32'd3);
        drive_pred(32'h40, 1'b1, 1'b0);  // index 19, untrained
        #1;
        check("gshare_pred_0x40", {31'd0, branch_predicted_taken}, 32'd0);
        drive_pred(32'h4C, 1'b1, 1'b0);  // 19 ^ 3 = 16, trained once
        #1;
        check("gshare_pred_0x4c", {31'd0, branch_predicted_taken}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bimodal_branch_predictor.md
BIMODAL_BRANCH_PREDICTOR -- requirements
Module: bimodal_branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/data width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 64, meaning branch history table depth (power of two, 4..4096).
REQ-003 SHALL have parameter COUNTER_BITS, default 2, meaning width of each saturating counter (1..4).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port pc  input  XLEN  address of instruction in RF stage.
REQ-007 SHALL have port pc_plus_four  input  XLEN  fall-through address.
REQ-008 SHALL have port branch_target  input  XLEN  computed target address.
REQ-009 SHALL have port jump  input  1  instruction is unconditional jump.
REQ-010 SHALL have port branch  input  1  instruction is conditional branch.
REQ-011 SHALL have port branch_predicted_taken  output  1  prediction.
REQ-012 SHALL have port predicted_next_instruction  output  XLEN  predicted fetch address.
REQ-013 SHALL have port update_valid  input  1  resolved conditional branch in DM stage.
REQ-014 SHALL have port update_pc  input  XLEN  address of resolved branch.
REQ-015 SHALL have port update_taken  input  1  evaluated outcome.
REQ-016 SHALL have port update_mispredicted  input  1  evaluated outcome differed from prediction.
REQ-017 SHALL have ports branch_count, mispredict_count  output  32  performance counters.

Function
REQ-018 SHALL index the table with pc[log2(BHT_ENTRIES)+1:2] (update side likewise with update_pc).
REQ-019 SHALL drive branch_predicted_taken combinationally: 1 if jump; MSB of indexed counter if branch; 0 otherwise.
REQ-020 SHALL drive predicted_next_instruction = branch_target when branch_predicted_taken, else pc_plus_four.
REQ-021 SHALL, on a clock edge with update_valid=1, increment the indexed counter if update_taken, else decrement it, saturating at all-ones and zero.
REQ-022 SHALL leave all counters unchanged when update_valid=0; jump SHALL never modify the table.
REQ-023 SHALL return the pre-update counter value to a prediction reading the same index being updated in that cycle (read-old).
REQ-024 SHALL increment branch_count on each edge with update_valid=1, and mispredict_count when additionally update_mispredicted=1; both wrap 0xFFFFFFFF -> 0.
REQ-025 SHALL ignore update_mispredicted when update_valid=0.
REQ-026 SHALL treat aliasing addresses (equal index bits) as sharing one counter.

Reset
REQ-027 SHALL, while reset=0, asynchronously set every counter to weakly-not-taken (2^(COUNTER_BITS-1)-1; 0 when COUNTER_BITS=1).
REQ-028 SHALL, while reset=0, clear branch_count, mispredict_count and any history register to 0.
REQ-029 SHALL discard an update coincident with reset assertion; reset mid-training SHALL restore all state to REQ-027/028 values.

Configuration
REQ-030 SHALL, with macro BRANCH_PREDICTOR_GSHARE_EN defined, keep a log2(BHT_ENTRIES)-bit global history register and index both ports with (pc index bits) XOR history.
REQ-031 SHALL, with BRANCH_PREDICTOR_GSHARE_EN defined, shift update_taken into history LSB on each update_valid edge, after computing that update's index with the old history.
REQ-032 SHALL, without BRANCH_PREDICTOR_GSHARE_EN, contain no history register and use pure PC indexing.

Verification
REQ-033 SHALL cover: reset, branch=1 pc=0x40 -> branch_predicted_taken=0, predicted_next_instruction=0x44.
REQ-034 SHALL cover: one update_valid, update_taken=1, update_pc=0x40 -> next prediction at 0x40 taken, predicted_next_instruction=branch_target.
REQ-035 SHALL cover: four taken updates at 0x40 then three not-taken -> counter 3 saturates, then 0; further not-taken keeps prediction 0.
REQ-036 SHALL cover: training 0x40 taken twice -> pc=0x140 (same index) predicted taken; pc=0x44 predicted not taken.
REQ-037 SHALL cover: 10 updates with 3 mispredicted -> branch_count=10, mispredict_count=3; reset asserted mid-sequence -> both 0 immediately, prediction at 0x40 not taken.
REQ-038 SHALL cover (GSHARE build): updates taken,taken at 0x40 -> history=0b000011; subsequent prediction at 0x40 reads index 16 XOR 3 = 19.
